// File: rtl/noc_port_merger_if.sv
// Flit bus bundle for noc_port_merger: NUM_IN input channels plus the merged output link.
interface noc_port_merger_if #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_IN-1:0]            in_valid;
   logic [NUM_IN-1:0]            in_ready;
   logic [NUM_IN*DATA_WIDTH-1:0] in_flit;
   logic [NUM_IN-1:0]            in_is_header;
   logic [NUM_IN-1:0]            in_is_tail;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_WIDTH-1:0]        out_flit;
   logic                         out_is_header;
   logic                         out_is_tail;
   logic                         err_orphan;
`ifdef NOC_MERGE_STATS_EN
   logic [15:0]                  out_pkt_count;
   logic [31:0]                  out_flit_count;

   modport slave (
      input  in_valid, in_flit, in_is_header, in_is_tail, out_ready,
      output in_ready, out_valid, out_flit, out_is_header, out_is_tail, err_orphan,
      output out_pkt_count, out_flit_count
   );
   modport master (
      output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
      input  in_ready, out_valid, out_flit, out_is_header, out_is_tail, err_orphan,
      input  out_pkt_count, out_flit_count
   );
`else
   modport slave (
      input  in_valid, in_flit, in_is_header, in_is_tail, out_ready,
      output in_ready, out_valid, out_flit, out_is_header, out_is_tail, err_orphan
   );
   modport master (
      output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
      input  in_ready, out_valid, out_flit, out_is_header, out_is_tail, err_orphan
   );
`endif
endinterface

// File: rtl/noc_port_merger.sv
// N-to-1 wormhole NoC link merger with per-channel FIFOs and round-robin packet arbitration.
// Optional traffic counters are compiled in with NOC_MERGE_STATS_EN.

// Per-channel flit FIFO, occupancy-count based full/empty.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: push_rdy = !full from registered state; held low during and one cycle after reset.
module noc_merge_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             noc_clk,
   input  logic             rst_n,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             rdy_en;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_rdy = rdy_en & ~full;
   assign pop_vld  = ~empty;
   assign pop_dat  = mem[rd_ptr];
   assign do_push  = push_vld & push_rdy;
   assign do_pop   = pop_rdy & ~empty;

   always_ff @(posedge noc_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         // Depth is a power of two, so natural pointer overflow is the modulo wrap.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge noc_clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

// Merges NUM_IN flit channels onto one link; a granted channel owns the link until its tail leaves.
// Latency: header pushed in N is granted in N+1 and valid on the output in N+2; one idle cycle between packets.
// Backpressure: out_ready low holds the output flit; the owner's FIFO fills and drops its in_ready.
module noc_port_merger #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input logic              noc_clk,
   input logic              rst_n,
   noc_port_merger_if.slave bus
);
   localparam int IW = $clog2(NUM_IN);

   typedef struct packed {
      logic                  hdr;
      logic                  tail;
      logic [DATA_WIDTH-1:0] dat;
   } flit_t;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   grant, grant_nxt;
   logic [IW-1:0]   rr, rr_nxt;
   logic            err, err_nxt;
   logic [NUM_IN-1:0] head_vld;
   logic [NUM_IN-1:0] pop;
   flit_t           push_dat [NUM_IN];
   flit_t           head     [NUM_IN];
   flit_t           head_g;
   logic            scan_hit;
   logic [IW-1:0]   scan_idx;
   logic            out_vld;
   logic            xfer;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_IN) s = s - NUM_IN;
      return IW'(s);
   endfunction

   for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
      assign push_dat[i] = '{hdr:  bus.in_is_header[i],
                             tail: bus.in_is_tail[i],
                             dat:  bus.in_flit[i*DATA_WIDTH +: DATA_WIDTH]};

      noc_merge_fifo #(
         .WIDTH ($bits(flit_t)),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .noc_clk  (noc_clk),
         .rst_n    (rst_n),
         .push_vld (bus.in_valid[i]),
         .push_rdy (bus.in_ready[i]),
         .push_dat (push_dat[i]),
         .pop_vld  (head_vld[i]),
         .pop_rdy  (pop[i]),
         .pop_dat  (head[i])
      );
   end

   // Walk from the highest offset down so the channel nearest rr wins.
   always_comb begin
      scan_hit = 1'b0;
      scan_idx = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (head_vld[wrap_inc(rr, k)]) begin
            scan_hit = 1'b1;
            scan_idx = wrap_inc(rr, k);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr;
      err_nxt   = err;
      pop       = '0;
      out_vld   = 1'b0;
      xfer      = 1'b0;
      head_g    = head[grant];
      case (state)
         IDLE: begin
            if (scan_hit) begin
               if (head[scan_idx].hdr) begin
                  grant_nxt = scan_idx;
                  state_nxt = LOCK;
               end else begin
                  pop[scan_idx] = 1'b1;
                  err_nxt       = 1'b1;
               end
            end
         end
         LOCK: begin
            out_vld = head_vld[grant];
            xfer    = out_vld & bus.out_ready;
            if (xfer) begin
               pop[grant] = 1'b1;
               if (head_g.tail) begin
                  rr_nxt    = wrap_inc(grant, 1);
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge noc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         rr    <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         rr    <= rr_nxt;
         err   <= err_nxt;
      end
   end

   assign bus.out_valid     = out_vld;
   assign bus.out_flit      = (state == LOCK) ? head_g.dat  : '0;
   assign bus.out_is_header = (state == LOCK) ? head_g.hdr  : 1'b0;
   assign bus.out_is_tail   = (state == LOCK) ? head_g.tail : 1'b0;
   assign bus.err_orphan    = err;

`ifdef NOC_MERGE_STATS_EN
   logic [15:0] pkt_cnt;
   logic [31:0] flit_cnt;

   always_ff @(posedge noc_clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         flit_cnt <= '0;
      end else begin
         if (xfer)                pkt_cnt  <= head_g.tail ? pkt_cnt + 16'd1 : pkt_cnt;
         if (xfer)                flit_cnt <= flit_cnt + 32'd1;
      end
   end

   assign bus.out_pkt_count  = pkt_cnt;
   assign bus.out_flit_count = flit_cnt;
`endif
endmodule

// File: tb/tb_noc_port_merger.sv
// Directed self-checking bench for noc_port_merger (4 channels, 32-bit flits, depth-4 FIFOs).
module tb_noc_port_merger;
   localparam int N = 4;
   localparam int W = 32;

   logic noc_clk = 1'b0;
   logic rst_n   = 1'b0;
   int   tests   = 0;
   int   fails   = 0;

   noc_port_merger_if #(.NUM_IN(N), .DATA_WIDTH(W)) bus ();

   noc_port_merger #(
      .NUM_IN     (N),
      .DATA_WIDTH (W),
      .FIFO_DEPTH (4)
   ) dut (
      .noc_clk (noc_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 noc_clk = ~noc_clk;

   task automatic clear_inputs();
      bus.in_valid     = '0;
      bus.in_flit      = '0;
      bus.in_is_header = '0;
      bus.in_is_tail   = '0;
   endtask

   task automatic drive(input int ch, input logic [W-1:0] d, input logic h, input logic t);
      bus.in_valid[ch]          = 1'b1;
      bus.in_flit[ch*W +: W]    = d;
      bus.in_is_header[ch]      = h;
      bus.in_is_tail[ch]        = t;
   endtask

   task automatic undrive(input int ch);
      bus.in_valid[ch] = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge noc_clk);
      rst_n = 1'b1;
      @(negedge noc_clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge noc_clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
      tests++;
      if (bus.in_ready !== 4'h0) begin fails++; $display("FAIL rst_in_ready got %h want 0", bus.in_ready); end
      tests++;
      if (bus.err_orphan !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", bus.err_orphan); end
      tests++;
      if ({bus.out_is_header, bus.out_is_tail, bus.out_flit} !== 34'h0) begin
         fails++; $display("FAIL rst_out_flit got %b%b %h want 0", bus.out_is_header, bus.out_is_tail, bus.out_flit);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (bus.in_ready !== 4'h0) begin fails++; $display("FAIL rst_release_ready got %h want 0", bus.in_ready); end
      @(negedge noc_clk);
      tests++;
      if (bus.in_ready !== 4'hF) begin fails++; $display("FAIL post_rst_ready got %h want f", bus.in_ready); end
   endtask

   task automatic test_single_packet();
      drive(1, 32'hA1, 1'b1, 1'b0);
      @(negedge noc_clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL sp_early_valid got %b want 0", bus.out_valid); end
      drive(1, 32'hA2, 1'b0, 1'b0);
      @(negedge noc_clk);
      tests++;
      if ({bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.out_flit} !== {3'b110, 32'hA1}) begin
         fails++; $display("FAIL sp_flit0 got %b%b%b %h want 110 a1", bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.out_flit);
      end
      drive(1, 32'hA3, 1'b0, 1'b1);
      @(negedge noc_clk);
      tests++;
      if ({bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.out_flit} !== {3'b100, 32'hA2}) begin
         fails++; $display("FAIL sp_flit1 got %b%b%b %h want 100 a2", bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.out_flit);
      end
      undrive(1);
      @(negedge noc_clk);
      tests++;
      if ({bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.out_flit} !== {3'b101, 32'hA3}) begin
         fails++; $display("FAIL sp_flit2 got %b%b%b %h want 101 a3", bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.out_flit);
      end
      @(negedge noc_clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL sp_idle got %b want 0", bus.out_valid); end
      tests++;
      if (dut.rr !== 2'd2) begin fails++; $display("FAIL sp_rr got %0d want 2", dut.rr); end
   endtask

   task automatic test_arbitration();
      logic          exp_v [7];
      logic [33:0]   exp_f [7];
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_f[0] = '0;
      exp_f[1] = {2'b10, 32'hB0};
      exp_f[2] = {2'b01, 32'hB1};
      exp_f[3] = '0;
      exp_f[4] = {2'b10, 32'hC0};
      exp_f[5] = {2'b01, 32'hC1};
      exp_f[6] = '0;
      do_reset();
      drive(0, 32'hB0, 1'b1, 1'b0);
      drive(2, 32'hC0, 1'b1, 1'b0);
      @(negedge noc_clk);
      drive(0, 32'hB1, 1'b0, 1'b1);
      drive(2, 32'hC1, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         if (i == 1) begin undrive(0); undrive(2); end
         tests++;
         if (bus.out_valid !== exp_v[i]) begin
            fails++; $display("FAIL arb_valid[%0d] got %b want %b", i, bus.out_valid, exp_v[i]);
         end else if (exp_v[i] && ({bus.out_is_header, bus.out_is_tail, bus.out_flit} !== exp_f[i])) begin
            fails++; $display("FAIL arb_flit[%0d] got %h want %h", i, {bus.out_is_header, bus.out_is_tail, bus.out_flit}, exp_f[i]);
         end
         @(negedge noc_clk);
      end
      tests++;
      if (dut.rr !== 2'd3) begin fails++; $display("FAIL arb_rr got %0d want 3", dut.rr); end
   endtask

   task automatic test_backpressure();
      int          pushed = 0;
      logic        acc;
      logic        unstable = 1'b0;
      logic [33:0] got [$];
      bus.out_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
         if (cyc == 9) begin
            tests++;
            if (pushed != 4) begin fails++; $display("FAIL bp_push_count got %0d want 4", pushed); end
            tests++;
            if (bus.in_ready[3] !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready[3]); end
            tests++;
            if ({bus.out_valid, bus.out_is_header, bus.out_flit} !== {2'b11, 32'hD0}) begin
               fails++; $display("FAIL bp_hold got %b%b %h want 11 d0", bus.out_valid, bus.out_is_header, bus.out_flit);
            end
         end
         if (cyc >= 2 && cyc < 10 && (bus.out_valid !== 1'b1 || bus.out_flit !== 32'hD0)) unstable = 1'b1;
         if (cyc == 10) bus.out_ready = 1'b1;
         if (pushed < 6) drive(3, 32'hD0 + pushed, pushed == 0, pushed == 5);
         else            undrive(3);
         acc = bus.in_valid[3] && bus.in_ready[3];
         if (bus.out_valid && bus.out_ready) got.push_back({bus.out_is_header, bus.out_is_tail, bus.out_flit});
         @(negedge noc_clk);
         if (acc) pushed++;
      end
      undrive(3);
      tests++;
      if (unstable) begin fails++; $display("FAIL bp_stable got changing output want d0 held"); end
      tests++;
      if (got.size() != 6) begin
         fails++; $display("FAIL bp_drain_count got %0d want 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (got[i] !== {(i == 0), (i == 5), 32'hD0 + i}) begin
               fails++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], {(i == 0), (i == 5), 32'hD0 + i});
            end
         end
      end
   endtask

   task automatic test_orphan();
      logic        saw_valid = 1'b0;
      logic [33:0] got [$];
      drive(2, 32'h55, 1'b0, 1'b0);
      @(negedge noc_clk);
      undrive(2);
      for (int c = 0; c < 4; c++) begin
         if (bus.out_valid) saw_valid = 1'b1;
         @(negedge noc_clk);
      end
      tests++;
      if (saw_valid) begin fails++; $display("FAIL orph_leak got out_valid=1 want 0"); end
      tests++;
      if (bus.err_orphan !== 1'b1) begin fails++; $display("FAIL orph_err got %b want 1", bus.err_orphan); end
      for (int c = 0; c < 8; c++) begin
         case (c)
            0: drive(2, 32'hE0, 1'b1, 1'b0);
            1: drive(2, 32'hE1, 1'b0, 1'b1);
            2: undrive(2);
            default: ;
         endcase
         if (bus.out_valid && bus.out_ready) got.push_back({bus.out_is_header, bus.out_is_tail, bus.out_flit});
         @(negedge noc_clk);
      end
      tests++;
      if (got.size() != 2 || got[0] !== {2'b10, 32'hE0} || got[1] !== {2'b01, 32'hE1}) begin
         fails++; $display("FAIL orph_follow got %0d flits (%h) want e0,e1", got.size(), (got.size() > 0) ? got[0] : 34'h0);
      end
      tests++;
      if (bus.err_orphan !== 1'b1) begin fails++; $display("FAIL orph_sticky got %b want 1", bus.err_orphan); end
   endtask

   task automatic test_reset_mid_packet();
      logic        saw_valid = 1'b0;
      logic [33:0] got [$];
      drive(3, 32'hF0, 1'b1, 1'b0);
      @(negedge noc_clk);
      drive(3, 32'hF1, 1'b0, 1'b0);
      @(negedge noc_clk);
      drive(3, 32'hF2, 1'b0, 1'b0);
      tests++;
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight got %b want 1", bus.out_valid); end
      #2;
      clear_inputs();
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.out_valid, bus.out_flit, bus.in_ready} !== 37'h0) begin
         fails++; $display("FAIL mid_rst_out got v=%b f=%h r=%h want 0", bus.out_valid, bus.out_flit, bus.in_ready);
      end
      @(negedge noc_clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge noc_clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      tests++;
      if (saw_valid || bus.err_orphan !== 1'b0) begin
         fails++; $display("FAIL mid_flushed got valid_seen=%b err=%b want 0 0", saw_valid, bus.err_orphan);
      end
      for (int c = 0; c < 10; c++) begin
         case (c)
            0: begin drive(1, 32'h61, 1'b1, 1'b1); drive(3, 32'h63, 1'b1, 1'b1); end
            1: begin undrive(1); undrive(3); end
            default: ;
         endcase
         if (bus.out_valid && bus.out_ready) got.push_back({bus.out_is_header, bus.out_is_tail, bus.out_flit});
         @(negedge noc_clk);
      end
      tests++;
      if (got.size() != 2 || got[0] !== {2'b11, 32'h61} || got[1] !== {2'b11, 32'h63}) begin
         fails++; $display("FAIL mid_rr_restart got %0d flits first=%h want 61 then 63", got.size(), (got.size() > 0) ? got[0] : 34'h0);
      end
   endtask

`ifdef NOC_MERGE_STATS_EN
   task automatic push_flit(input int ch, input logic [W-1:0] d, input logic h, input logic t);
      int n = 0;
      while (!bus.in_ready[ch] && n < 50) begin
         @(negedge noc_clk);
         n++;
      end
      if (n >= 50) begin tests++; fails++; $display("FAIL push_timeout ch%0d got stuck want ready", ch); end
      drive(ch, d, h, t);
      @(negedge noc_clk);
      undrive(ch);
   endtask

   task automatic test_stats();
      int lens [3] = '{3, 2, 2};
      do_reset();
      bus.out_ready = 1'b1;
      for (int p = 0; p < 3; p++)
         for (int f = 0; f < lens[p]; f++)
            push_flit(0, 32'h100 * p + f, f == 0, f == lens[p] - 1);
      repeat (20) @(negedge noc_clk);
      tests++;
      if (bus.out_pkt_count !== 16'd3) begin fails++; $display("FAIL stats_pkt got %0d want 3", bus.out_pkt_count); end
      tests++;
      if (bus.out_flit_count !== 32'd7) begin fails++; $display("FAIL stats_flit got %0d want 7", bus.out_flit_count); end
      force dut.pkt_cnt = 16'hFFFF;
      @(negedge noc_clk);
      release dut.pkt_cnt;
      push_flit(0, 32'h777, 1'b1, 1'b1);
      repeat (10) @(negedge noc_clk);
      tests++;
      if (bus.out_pkt_count !== 16'd0) begin fails++; $display("FAIL stats_wrap got %h want 0", bus.out_pkt_count); end
      tests++;
      if (bus.out_flit_count !== 32'd8) begin fails++; $display("FAIL stats_flit8 got %0d want 8", bus.out_flit_count); end
   endtask
`endif

   initial begin
      clear_inputs();
      bus.out_ready = 1'b1;
      test_reset();
      test_single_packet();
      test_arbitration();
      test_backpressure();
      test_orphan();
      test_reset_mid_packet();
`ifdef NOC_MERGE_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/noc_port_merger.md
Name: noc_port_merger

Overview:
- Parametrised N-to-1 NoC link merger: NUM_IN flit input channels, each with its own FIFO, merged onto one output link.
- Sits between local/upstream channels and a single router ingress port.
- Uses valid/ready flit handshake with header/tail framing.
- Wormhole (packet-level) arbitration: once a channel wins, it owns the output until its tail flit leaves; channels are served round-robin.

Parameters:
- NUM_IN, 4, number of input channels (2..8).
- DATA_WIDTH, 32, flit payload width in bits.
- FIFO_DEPTH, 4, flits per input FIFO; power of two, at least 2.

Ports:
- noc_clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_IN  per-channel flit valid.
- in_ready  output  NUM_IN  per-channel FIFO can accept.
- in_flit  input  NUM_IN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_is_header  input  NUM_IN  flit is the first flit of its packet.
- in_is_tail  input  NUM_IN  flit is the last flit of its packet.
- out_valid  output  1  output flit valid.
- out_ready  input  1  downstream accepts.
- out_flit  output  DATA_WIDTH  output payload.
- out_is_header  output  1  header marker of out_flit.
- out_is_tail  output  1  tail marker of out_flit.
- err_orphan  output  1  sticky flag: a non-header flit was found at a FIFO head while the merger was IDLE.

Behaviour:
- Clock/reset: one clock, noc_clk. rst_n is asynchronous and active-low.
- Reset (asserted any time, including mid-packet):
  - All FIFOs are emptied.
  - FSM goes to IDLE; round-robin pointer rr = 0.
  - err_orphan = 0, out_valid = 0; out_flit, out_is_header and out_is_tail drive 0.
  - in_ready goes high one cycle after rst_n deasserts; it reads 0 while rst_n is low.
- Input side:
  - in_ready[i] = !full[i], driven from registered state only (no combinational path from in_valid).
  - A push happens when in_valid[i] && in_ready[i].
  - A pop in the same cycle does not make room for a push when the FIFO is full.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH; full/empty are decided by the occupancy count.
- FSM:
  - IDLE:
    - Scan non-empty channels starting at rr, wrapping.
    - If the first found head flit has is_header = 1: grant that channel g (registered) and go to LOCK. out_valid stays 0 this cycle.
    - If the found head is not a header: pop and discard it, set err_orphan, stay IDLE. At most one discard per cycle.
  - LOCK:
    - out_valid = !empty[g]; out_flit, out_is_header and out_is_tail show the head of FIFO g.
    - On transfer (out_valid && out_ready) pop FIFO g.
    - If the transferred flit has is_tail = 1: set rr = (g+1) mod NUM_IN and go to IDLE.
    - A header+tail single-flit packet follows the same rule.
    - If FIFO g empties mid-packet: out_valid drops and the merger stays LOCKed on g, waiting; other channels are not served.
- Output handshake:
  - While out_valid = 1 and out_ready = 0, out_flit and its markers hold stable.
  - out_valid is never withdrawn without a transfer.
- Latency and throughput:
  - A flit pushed in cycle N is at the FIFO head in N+1.
  - A header reaching an IDLE merger is granted in N+1 and appears on out_valid in N+2.
  - Within a packet, one flit per cycle when the FIFO is non-empty and out_ready = 1.
  - One IDLE bubble cycle between consecutive packets.
- Fairness: after channel g finishes a packet, g has the lowest priority for the next grant.
- err_orphan is cleared only by reset.

Optional Feature:
- Macro: NOC_MERGE_STATS_EN.
- Defined:
  - Adds output out_pkt_count [15:0], reset 0.
  - Increments by 1 on every transferred tail flit; wraps 16'hFFFF -> 0.
  - Adds output out_flit_count [31:0] counting every output transfer, same reset and wrap rules.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then a single 3-flit packet on ch1 (flits 0xA1 header, 0xA2, 0xA3 tail), out_ready = 1 -> out_valid first high 2 cycles after the header push; 0xA1, 0xA2, 0xA3 on consecutive cycles; markers correct; FSM returns to IDLE.
- ch0 and ch2 both present 2-flit packets in the same cycle, rr = 0 -> ch0 packet sent completely, one idle cycle, then ch2 packet; no interleaving; rr ends at 3.
- Hold out_ready = 0 with 6 flits offered on ch3 at FIFO_DEPTH = 4 -> in_ready[3] drops after 4 pushes; out_flit stable; releasing out_ready drains all 6 flits in order.
- Non-header flit 0x55 pushed on idle ch2 -> flit discarded, never seen on output; err_orphan = 1 and stays 1; a following valid packet on ch2 passes normally.
- Assert rst_n low while a 4-flit packet is 2 flits in -> out_valid = 0 immediately; FIFOs empty; after release a new packet from ch1 is granted first (rr = 0 scan).
- With NOC_MERGE_STATS_EN: send 3 packets totalling 7 flits -> out_pkt_count = 3, out_flit_count = 7; force out_pkt_count = 16'hFFFF then send 1 packet -> 0.
